// File: rtl/smi_axis_output_adaptor_if.sv
// SMI-in / AXI-Stream-out signal bundle for smi_axis_output_adaptor.
// slave is the adaptor's view; master is the driver/sink view.
interface smi_axis_output_adaptor_if #(
  parameter int unsigned DataIndexSize = 3,
  parameter int unsigned UserWidth     = 1
);
  localparam int unsigned KeepWidth = 1 << DataIndexSize;
  localparam int unsigned DataWidth = KeepWidth * 8;

  logic                 smiInValid;
  logic [DataWidth-1:0] smiInData;
  logic [7:0]           smiInEofc;
  logic [UserWidth-1:0] smiInUser;
  logic                 smiInStop;

  logic                 axisOutValid;
  logic [DataWidth-1:0] axisOutData;
  logic [KeepWidth-1:0] axisOutKeep;
  logic [UserWidth-1:0] axisOutUser;
  logic                 axisOutLast;
  logic                 axisOutReady;

  modport slave (
    input  smiInValid, smiInData, smiInEofc, smiInUser,
    output smiInStop,
    output axisOutValid, axisOutData, axisOutKeep, axisOutUser, axisOutLast,
    input  axisOutReady
  );

  modport master (
    output smiInValid, smiInData, smiInEofc, smiInUser,
    input  smiInStop,
    input  axisOutValid, axisOutData, axisOutKeep, axisOutUser, axisOutLast,
    output axisOutReady
  );
endinterface

// File: rtl/smi_axis_output_adaptor.sv
// SMI frame to AXI Stream adaptor with a 2-entry skid FIFO, EOFC decode and frame tracking.
// Optional completed-frame counter enabled by SMI_AXIS_OUTPUT_ADAPTOR_FRAME_COUNT_EN.
module smi_axis_output_adaptor #(
  parameter int unsigned DataIndexSize = 3,
  parameter int unsigned UserWidth     = 1
) (
  input  logic                    clk,
  input  logic                    srst_n,
  smi_axis_output_adaptor_if.slave bus_if,
  output logic                    frameActive,
  output logic                    eofcError,
  output logic [31:0]             frameCount
);
  localparam int unsigned KeepWidth = 1 << DataIndexSize;
  localparam int unsigned DataWidth = KeepWidth * 8;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t               state_q, state_d;
  logic [1:0]           count_q, count_d;
  logic [DataWidth-1:0] data_q [2];
  logic [DataWidth-1:0] data_d [2];
  logic [KeepWidth-1:0] keep_q [2];
  logic [KeepWidth-1:0] keep_d [2];
  logic [UserWidth-1:0] user_q [2];
  logic [UserWidth-1:0] user_d [2];
  logic [1:0]           last_q, last_d;
  logic                 eofc_error_q, eofc_error_d;

  logic                 accept, xfer, wr_hi;
  logic [KeepWidth-1:0] keep_c;
  logic                 last_c, eofc_bad_c;

  assign accept = bus_if.smiInValid && (count_q != 2'd2);
  assign xfer   = (count_q != 2'd0) && bus_if.axisOutReady;
  // After a pop the free slot is 0 unless one entry stays behind.
  assign wr_hi  = (count_q == 2'd1) && !xfer;

  // EOFC decode: low eofc bytes valid, anything beyond the flit width is malformed.
  always_comb begin
    keep_c     = '1;
    last_c     = (bus_if.smiInEofc != 8'd0);
    eofc_bad_c = 1'b0;
    if (bus_if.smiInEofc != 8'd0) begin
      for (int i = 0; i < int'(KeepWidth); i++) begin
        keep_c[i] = (32'(i) < 32'(bus_if.smiInEofc));
      end
      eofc_bad_c = (32'(bus_if.smiInEofc) > 32'(KeepWidth));
    end
  end

  // FIFO next state: shift on pop, then write the accepted flit behind the head.
  always_comb begin
    data_d  = data_q;
    keep_d  = keep_q;
    user_d  = user_q;
    last_d  = last_q;
    count_d = count_q + 2'(accept) - 2'(xfer);
    if (xfer) begin
      data_d[0] = data_q[1];
      keep_d[0] = keep_q[1];
      user_d[0] = user_q[1];
      last_d[0] = last_q[1];
    end
    if (accept) begin
      data_d[wr_hi] = bus_if.smiInData;
      keep_d[wr_hi] = keep_c;
      user_d[wr_hi] = bus_if.smiInUser;
      last_d[wr_hi] = last_c;
    end
  end

  // Frame tracking and sticky error.
  always_comb begin
    state_d      = state_q;
    eofc_error_d = eofc_error_q;
    if (accept) begin
      state_d      = last_c ? IDLE : ACTIVE;
      eofc_error_d = eofc_error_q | eofc_bad_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      count_q      <= 2'd0;
      state_q      <= IDLE;
      eofc_error_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      state_q      <= state_d;
      eofc_error_q <= eofc_error_d;
    end
  end

  // Payload storage needs no reset; it is only observed while count_q is non-zero.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    keep_q <= keep_d;
    user_q <= user_d;
    last_q <= last_d;
  end

  assign bus_if.smiInStop    = (count_q == 2'd2);
  assign bus_if.axisOutValid = (count_q != 2'd0);
  assign bus_if.axisOutData  = data_q[0];
  assign bus_if.axisOutUser  = user_q[0];
  assign bus_if.axisOutKeep  = (count_q != 2'd0) ? keep_q[0] : '0;
  assign bus_if.axisOutLast  = (count_q != 2'd0) && last_q[0];
  assign frameActive         = (state_q == ACTIVE);
  assign eofcError           = eofc_error_q;

`ifdef SMI_AXIS_OUTPUT_ADAPTOR_FRAME_COUNT_EN
  logic [31:0] frame_count_q;

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      frame_count_q <= 32'd0;
    end else if (xfer && last_q[0]) begin
      frame_count_q <= frame_count_q + 32'd1;
    end
  end

  assign frameCount = frame_count_q;
`else
  assign frameCount = 32'd0;
`endif
endmodule

// File: tb/tb_smi_axis_output_adaptor.sv
// Directed and randomised-handshake bench for smi_axis_output_adaptor (DataIndexSize=3).
module tb_smi_axis_output_adaptor;
`ifdef SMI_AXIS_OUTPUT_ADAPTOR_FRAME_COUNT_EN
  localparam bit FcEn = 1'b1;
`else
  localparam bit FcEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        srst_n;
  logic        frameActive, eofcError;
  logic [31:0] frameCount;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  smi_axis_output_adaptor_if #(.DataIndexSize(3), .UserWidth(1)) bus ();

  smi_axis_output_adaptor #(.DataIndexSize(3), .UserWidth(1)) dut (
    .clk         (clk),
    .srst_n      (srst_n),
    .bus_if      (bus),
    .frameActive (frameActive),
    .eofcError   (eofcError),
    .frameCount  (frameCount)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [63:0] d, input logic [7:0] e);
    bus.smiInValid = v;
    bus.smiInData  = d;
    bus.smiInEofc  = e;
    bus.smiInUser  = d[0];
  endtask

  task automatic chk_beat(input string tag, input logic [63:0] d, input logic [7:0] k, input logic l);
    chk({tag, "_valid"}, 64'(bus.axisOutValid), 64'd1);
    chk({tag, "_data"},  bus.axisOutData, d);
    chk({tag, "_keep"},  64'(bus.axisOutKeep), 64'(k));
    chk({tag, "_last"},  64'(bus.axisOutLast), 64'(l));
  endtask

  function automatic logic [7:0] exp_keep(input logic [7:0] e);
    if (e == 8'd0 || e >= 8'd8) return 8'hFF;
    return 8'((16'd1 << e) - 16'd1);
  endfunction

  function automatic logic [63:0] fc(input int n);
    return FcEn ? 64'(n) : 64'd0;
  endfunction

  logic [63:0] q_data[$];
  logic [7:0]  q_keep[$];
  logic        q_last[$];
  logic        q_user[$];

  initial begin
    int          mcnt, sent, cyc;
    logic        pend, vld, rdy, acc, xf;
    logic [63:0] pd;
    logic [7:0]  pe;

    srst_n = 1'b0;
    offer(1'b0, 64'd0, 8'd0);
    bus.axisOutReady = 1'b1;
    tick();
    tick();
    chk("rst_valid", 64'(bus.axisOutValid), 64'd0);
    chk("rst_stop",  64'(bus.smiInStop), 64'd0);
    chk("rst_keep",  64'(bus.axisOutKeep), 64'd0);
    chk("rst_last",  64'(bus.axisOutLast), 64'd0);
    chk("rst_active", 64'(frameActive), 64'd0);
    chk("rst_err",   64'(eofcError), 64'd0);
    chk("rst_fc",    64'(frameCount), 64'd0);
    srst_n = 1'b1;
    tick();

    // Single-flit frame
    offer(1'b1, 64'h1122334455667788, 8'd3);
    tick();
    offer(1'b0, 64'd0, 8'd0);
    chk_beat("single", 64'h1122334455667788, 8'h07, 1'b1);
    chk("single_user", 64'(bus.axisOutUser), 64'd0);
    chk("single_active", 64'(frameActive), 64'd0);
    tick();
    chk("single_empty", 64'(bus.axisOutValid), 64'd0);
    chk("single_fc", 64'(frameCount), fc(1));

    // Three-flit frame
    offer(1'b1, 64'hA0A0_0000_0000_0001, 8'd0);
    tick();
    chk("f3_active0", 64'(frameActive), 64'd1);
    chk_beat("f3_b0", 64'hA0A0_0000_0000_0001, 8'hFF, 1'b0);
    chk("f3_user0", 64'(bus.axisOutUser), 64'd1);
    offer(1'b1, 64'hA0A0_0000_0000_0002, 8'd0);
    tick();
    chk("f3_active1", 64'(frameActive), 64'd1);
    chk_beat("f3_b1", 64'hA0A0_0000_0000_0002, 8'hFF, 1'b0);
    offer(1'b1, 64'hA0A0_0000_0000_0003, 8'd8);
    tick();
    offer(1'b0, 64'd0, 8'd0);
    chk("f3_active2", 64'(frameActive), 64'd0);
    chk_beat("f3_b2", 64'hA0A0_0000_0000_0003, 8'hFF, 1'b1);
    tick();
    chk("f3_empty", 64'(bus.axisOutValid), 64'd0);
    chk("f3_fc", 64'(frameCount), fc(2));

    // Backpressure: ready low, third flit must be held off
    bus.axisOutReady = 1'b0;
    offer(1'b1, 64'hB000_0000_0000_000A, 8'd0);
    tick();
    chk("bp_stop1", 64'(bus.smiInStop), 64'd0);
    offer(1'b1, 64'hB000_0000_0000_000B, 8'd0);
    tick();
    chk("bp_stop2", 64'(bus.smiInStop), 64'd1);
    offer(1'b1, 64'hB000_0000_0000_000C, 8'd5);
    tick();
    chk("bp_stop3", 64'(bus.smiInStop), 64'd1);
    chk_beat("bp_hold", 64'hB000_0000_0000_000A, 8'hFF, 1'b0);
    tick();
    chk_beat("bp_hold2", 64'hB000_0000_0000_000A, 8'hFF, 1'b0);
    bus.axisOutReady = 1'b1;
    tick();
    chk("bp_stop_rel", 64'(bus.smiInStop), 64'd0);
    chk_beat("bp_b1", 64'hB000_0000_0000_000B, 8'hFF, 1'b0);
    tick();
    offer(1'b0, 64'd0, 8'd0);
    chk_beat("bp_b2", 64'hB000_0000_0000_000C, 8'h1F, 1'b1);
    tick();
    chk("bp_empty", 64'(bus.axisOutValid), 64'd0);
    chk("bp_fc", 64'(frameCount), fc(3));

    // Malformed EOFC values
    offer(1'b1, 64'hE000_0000_0000_00FF, 8'hFF);
    tick();
    chk_beat("eofc_ff", 64'hE000_0000_0000_00FF, 8'hFF, 1'b1);
    chk("eofc_ff_err", 64'(eofcError), 64'd1);
    offer(1'b1, 64'hE000_0000_0000_0009, 8'd9);
    tick();
    chk_beat("eofc_9", 64'hE000_0000_0000_0009, 8'hFF, 1'b1);
    offer(1'b1, 64'hE000_0000_0000_0002, 8'd2);
    tick();
    offer(1'b0, 64'd0, 8'd0);
    chk_beat("eofc_ok", 64'hE000_0000_0000_0002, 8'h03, 1'b1);
    chk("eofc_sticky", 64'(eofcError), 64'd1);
    tick();
    chk("eofc_fc", 64'(frameCount), fc(6));

    // Reset with two flits buffered mid-frame
    bus.axisOutReady = 1'b0;
    offer(1'b1, 64'hC000_0000_0000_0001, 8'd0);
    tick();
    offer(1'b1, 64'hC000_0000_0000_0002, 8'd0);
    tick();
    chk("mid_active", 64'(frameActive), 64'd1);
    chk("mid_stop", 64'(bus.smiInStop), 64'd1);
    offer(1'b0, 64'd0, 8'd0);
    srst_n = 1'b0;
    tick();
    srst_n = 1'b1;
    chk("mrst_valid", 64'(bus.axisOutValid), 64'd0);
    chk("mrst_active", 64'(frameActive), 64'd0);
    chk("mrst_err", 64'(eofcError), 64'd0);
    chk("mrst_stop", 64'(bus.smiInStop), 64'd0);
    chk("mrst_keep", 64'(bus.axisOutKeep), 64'd0);
    chk("mrst_fc", 64'(frameCount), 64'd0);
    tick();
    chk("mrst_idle", 64'(bus.axisOutValid), 64'd0);
    bus.axisOutReady = 1'b1;
    offer(1'b1, 64'hD000_0000_0000_0001, 8'd0);
    tick();
    chk_beat("fresh_b0", 64'hD000_0000_0000_0001, 8'hFF, 1'b0);
    offer(1'b1, 64'hD000_0000_0000_0002, 8'd4);
    tick();
    offer(1'b0, 64'd0, 8'd0);
    chk_beat("fresh_b1", 64'hD000_0000_0000_0002, 8'h0F, 1'b1);
    tick();
    chk("fresh_empty", 64'(bus.axisOutValid), 64'd0);
    chk("fresh_fc", 64'(frameCount), fc(1));

    // Random valid/ready handshake against a scoreboard
    mcnt = 0;
    sent = 0;
    cyc  = 0;
    pend = 1'b0;
    pd   = 64'd0;
    pe   = 8'd0;
    while ((sent < 1000 || q_data.size() != 0) && cyc < 20000) begin
      if (!pend && sent < 1000) begin
        pd   = {32'($urandom), 32'($urandom)};
        pe   = ($urandom_range(0, 3) < 2) ? 8'd0 : 8'($urandom_range(1, 8));
        pend = 1'b1;
      end
      vld = pend && ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      offer(vld, pd, pe);
      bus.axisOutReady = rdy;
      chk("rnd_stop", 64'(bus.smiInStop), 64'(mcnt == 2));
      chk("rnd_valid", 64'(bus.axisOutValid), 64'(mcnt != 0));
      acc = vld && (mcnt != 2);
      xf  = (mcnt != 0) && rdy;
      if (xf) begin
        chk_beat("rnd", q_data[0], q_keep[0], q_last[0]);
        chk("rnd_user", 64'(bus.axisOutUser), 64'(q_user[0]));
        void'(q_data.pop_front());
        void'(q_keep.pop_front());
        void'(q_last.pop_front());
        void'(q_user.pop_front());
      end
      if (acc) begin
        q_data.push_back(pd);
        q_keep.push_back(exp_keep(pe));
        q_last.push_back(pe != 8'd0);
        q_user.push_back(pd[0]);
        pend = 1'b0;
        sent++;
      end
      tick();
      mcnt = mcnt + int'(acc) - int'(xf);
      cyc++;
    end
    offer(1'b0, 64'd0, 8'd0);
    chk("rnd_sent", 64'(sent), 64'd1000);
    chk("rnd_drain", 64'(q_data.size()), 64'd0);
    chk("rnd_err", 64'(eofcError), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/smi_axis_output_adaptor.md
Name: smi_axis_output_adaptor

Overview:
- Converts SMI frames back into AXI Stream beats. It is the stage directly downstream of the AXI Stream to SMI input adaptor and sits at the SMI-to-external-AXI boundary.
- Uses a 2-entry registered buffer to decouple SMI stop backpressure from AXI ready.
- Decodes SMI EOFC into AXI keep/last.
- Tracks frame state and flags malformed EOFC values.

Parameters:
- DataIndexSize, 3, log2 of bytes per flit.
- UserWidth, 1, width of the out-of-band user field; tie low if unused.
- DataWidth, (1<<DataIndexSize)*8, derived data width.
- KeepWidth, (1<<DataIndexSize), derived keep width.

Ports:
- clk  input  1  clock, all logic rising-edge.
- srst_n  input  1  synchronous reset, active-low.
- smiInValid  input  1  SMI flit valid.
- smiInData  input  DataWidth  SMI flit data.
- smiInEofc  input  8  SMI end-of-frame control; 0 means mid-frame.
- smiInUser  input  UserWidth  user sideband.
- smiInStop  output  1  SMI backpressure.
- axisOutValid  output  1  AXI beat valid.
- axisOutData  output  DataWidth  AXI data.
- axisOutKeep  output  KeepWidth  AXI byte keep.
- axisOutUser  output  UserWidth  AXI user.
- axisOutLast  output  1  AXI last.
- axisOutReady  input  1  AXI ready.
- frameActive  output  1  high between first accepted flit of a frame and acceptance of its final flit.
- eofcError  output  1  sticky malformed-EOFC flag.
- frameCount  output  32  completed AXI frames (see Optional Feature).

Behaviour:
- Reset: clock edge with srst_n=0 clears buffer count, frameActive, eofcError, frameCount. During and after reset:
  - axisOutValid=0, smiInStop=0, axisOutLast=0, axisOutKeep=0.
  - Data/user may hold stale values.
- Reset mid-frame:
  - Buffered flits are discarded.
  - No partial beat is emitted after reset.
- SMI accept: smiInValid && !smiInStop on a clock edge.
- AXI transfer: axisOutValid && axisOutReady.
- Buffer:
  - 2-entry FIFO, count 0..2.
  - smiInStop = (count==2), driven straight from the count register; no combinational path from axisOutReady.
  - axisOutValid = (count!=0); head entry drives the AXI outputs.
  - Latency: accepted flit appears on AXI the next cycle.
  - Simultaneous accept and transfer: count unchanged, order preserved.
  - Sustains one flit/cycle while axisOutReady=1.
  - AXI outputs hold stable while valid && !ready.
- EOFC decode, done at input before storing:
  - eofc==0: last=0, keep all ones.
  - 1<=eofc<=KeepWidth: last=1, keep=(1<<eofc)-1, i.e. eofc low bytes valid.
  - eofc>KeepWidth (incl. 0xFF): last=1, keep all ones, eofcError set on accept.
- Frame state machine, advanced on SMI accepts:
  - IDLE -> ACTIVE on accept with eofc==0.
  - ACTIVE -> IDLE on accept with eofc!=0.
  - A single-flit frame (eofc!=0 from IDLE) stays IDLE.
  - frameActive=1 in ACTIVE.
- eofcError is cleared only by reset.
- Data and user pass through unmodified.

Optional Feature:
- Macro: SMI_AXIS_OUTPUT_ADAPTOR_FRAME_COUNT_EN.
- Defined: frameCount increments by 1 on each AXI transfer with axisOutLast=1. It wraps 0xFFFFFFFF->0.
- Undefined: frameCount is tied to 0 and no counter logic is built.
- Port is present in both builds.

Test Plan (DataIndexSize=3):
- Single flit, data 0x1122334455667788, eofc=3, ready=1 -> next cycle one beat, same data, keep=0x07, last=1; frameActive stays 0; frameCount=1 if enabled.
- 3-flit frame, eofc 0,0,8, ready=1 -> beats keep 0xFF,0xFF,0xFF with last 0,0,1. frameActive is 1 after the first accept and 0 after the third.
- Ready held 0, 3 flits offered -> smiInStop=1 after 2 accepts, third flit held. When ready rises, the 3 beats arrive in order with no loss or duplication.
- eofc=0xFF flit, then eofc=9 flit -> both give last=1, keep=0xFF. eofcError=1 and stays 1 through later valid frames.
- srst_n=0 for 1 cycle with 2 flits buffered mid-frame -> next cycle axisOutValid=0, frameActive=0, eofcError=0, smiInStop=0; a fresh frame then passes normally.
- Random valid/ready toggling over 1000 flits -> AXI stream exactly matches scoreboard; count never exceeds 2.
